// File: rtl/i2c_ram_pkg.sv
// i2c_ram_pkg: shared RAM widths, requester ids and arbiter states
package i2c_ram_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {ID_USR = 2'd0, ID_MST = 2'd1, ID_SLV = 2'd2} req_id_t;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
endpackage

// File: rtl/i2c_ram_32x8.sv
// i2c_ram_32x8: single-port synchronous RAM, 1-cycle read latency, write-first
module i2c_ram_32x8
    import i2c_ram_pkg::*;
#(
    parameter int ADDR_W = i2c_ram_pkg::ADDR_W,
    parameter int DATA_W = i2c_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= we ? wdata : mem[addr];
        end
    end
endmodule

// File: rtl/i2c_ram_arbiter.sv
// i2c_ram_arbiter: registered req/gnt scheduler sharing one RAM among usr, mst and slv
module i2c_ram_arbiter
    import i2c_ram_pkg::*;
#(
    parameter int ADDR_W     = i2c_ram_pkg::ADDR_W,
    parameter int DATA_W     = i2c_ram_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              usr_req,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_gnt,
    output logic              usr_rvalid,
    output logic [DATA_W-1:0] usr_rdata,
    input  logic              mst_req,
    input  logic [ADDR_W-1:0] mst_addr,
    input  logic [DATA_W-1:0] mst_wdata,
    output logic              mst_gnt,
    input  logic              slv_req,
    input  logic [ADDR_W-1:0] slv_addr,
    output logic              slv_gnt,
    output logic              slv_rvalid,
    output logic [DATA_W-1:0] slv_rdata,
    output logic              busy
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    arb_state_t        state, state_nx;
    req_id_t           id_q, win;
    logic              we_q, go, any_req, arb;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, ram_q, usr_hold, slv_hold;
    logic [CW-1:0]     starve_cnt;
    assign any_req = usr_req | mst_req | slv_req;
    assign arb = state == IDLE && any_req;
    assign win = (usr_req && starve_cnt == CW'(STARVE_MAX)) ? ID_USR :
                 slv_req ? ID_SLV : mst_req ? ID_MST : ID_USR;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = arb ? GRANT : IDLE;
    end
    always_comb begin
        go      = state == GRANT && rst_n;
        busy    = state == GRANT;
        usr_gnt = go && id_q == ID_USR;
        mst_gnt = go && id_q == ID_MST;
        slv_gnt = go && id_q == ID_SLV;
    end
    always_ff @(posedge clk) begin
        if (arb) begin
            id_q    <= win;
            we_q    <= win == ID_MST || (win == ID_USR && usr_we);
            addr_q  <= win == ID_USR ? usr_addr : win == ID_MST ? mst_addr : slv_addr;
            wdata_q <= win == ID_USR ? usr_wdata : mst_wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n || !usr_req) starve_cnt <= '0;
        else if (arb) starve_cnt <= win == ID_USR ? '0 :
                                    starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            usr_rvalid <= 1'b0;
            slv_rvalid <= 1'b0;
            usr_hold   <= '0;
            slv_hold   <= '0;
        end else begin
            usr_rvalid <= usr_gnt && !we_q;
            slv_rvalid <= slv_gnt;
            if (usr_rvalid) usr_hold <= ram_q;
            if (slv_rvalid) slv_hold <= ram_q;
        end
    end
    assign usr_rdata = usr_rvalid ? ram_q : usr_hold;
    assign slv_rdata = slv_rvalid ? ram_q : slv_hold;
    i2c_ram_32x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .en    (go),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// tb_i2c_ram_arbiter: directed and random accesses checked against an array model of the RAM
module tb_i2c_ram_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       usr_req = 1'b0, usr_we = 1'b0, usr_gnt, usr_rvalid;
    logic [4:0] usr_addr = '0, mst_addr = '0, slv_addr = '0;
    logic [7:0] usr_wdata = '0, mst_wdata = '0, usr_rdata, slv_rdata;
    logic       mst_req = 1'b0, mst_gnt, slv_req = 1'b0, slv_gnt, slv_rvalid, busy;
    logic [7:0] model [32];
    int         checks = 0, errors = 0;
    always #5 clk = ~clk;
    i2c_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
        .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata),
        .mst_req(mst_req), .mst_addr(mst_addr), .mst_wdata(mst_wdata), .mst_gnt(mst_gnt),
        .slv_req(slv_req), .slv_addr(slv_addr), .slv_gnt(slv_gnt),
        .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata), .busy(busy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // who: 0 = usr, 1 = mst (always write), 2 = slv (always read)
    task automatic access(input int who, input logic we, input logic [4:0] a, input logic [7:0] d);
        int   n;
        logic rd;
        rd = who == 2 || (who == 0 && !we);
        @(posedge clk); #1;
        if (who == 0) begin usr_req = 1; usr_we = we; usr_addr = a; usr_wdata = d; end
        else if (who == 1) begin mst_req = 1; mst_addr = a; mst_wdata = d; end
        else begin slv_req = 1; slv_addr = a; end
        n = 0;
        do begin @(negedge clk); n++; end while ({slv_gnt, mst_gnt, usr_gnt} == 3'b000 && n < 10);
        chk("acc_latency", n, 2);
        chk("acc_gnt", {slv_gnt, mst_gnt, usr_gnt}, 3'b001 << who);
        chk("acc_busy", busy, 1);
        @(posedge clk); #1;
        usr_req = 0; mst_req = 0; slv_req = 0;
        @(negedge clk);
        chk("acc_rvalid", {usr_rvalid, slv_rvalid}, !rd ? 2'b00 : who == 0 ? 2'b10 : 2'b01);
        if (rd) chk("acc_rdata", who == 0 ? usr_rdata : slv_rdata, model[a]);
        else model[a] = d;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
    initial begin
        int n, ns, w;
        logic [7:0] old;
        usr_req = 1; usr_we = 1; mst_req = 1; slv_req = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", {usr_gnt, mst_gnt, slv_gnt}, 3'b000);
            chk("rst_rvalid", {usr_rvalid, slv_rvalid}, 2'b00);
            chk("rst_busy", busy, 0);
            chk("rst_rdata", {usr_rdata, slv_rdata}, 16'h0000);
        end
        @(posedge clk); #1;
        usr_req = 0; mst_req = 0; slv_req = 0; rst_n = 1;
        access(1, 1, 5'h03, 8'hA5);
        access(0, 0, 5'h03, 8'h00);
        chk("mw_usr_rdata_const", usr_rdata, 8'hA5);
        access(0, 1, 5'h07, 8'h11);
        old = model[7];
        @(posedge clk); #1;
        slv_req = 1; slv_addr = 5'h07; mst_req = 1; mst_addr = 5'h07; mst_wdata = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        chk("coll_first_gnt", {slv_gnt, mst_gnt, usr_gnt}, 3'b100);
        @(posedge clk); #1;
        slv_req = 0;
        @(negedge clk);
        chk("coll_slv_rvalid", slv_rvalid, 1);
        chk("coll_slv_old", slv_rdata, old);
        chk("coll_mst_wait", mst_gnt, 0);
        @(negedge clk);
        chk("coll_mst_gnt", mst_gnt, 1);
        model[7] = 8'h3C;
        @(posedge clk); #1;
        mst_req = 0;
        @(negedge clk);
        chk("coll_slv_hold", slv_rdata, 8'h11);
        access(2, 0, 5'h07, 8'h00);
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            slv_req = 1; slv_addr = 5'h07; usr_req = 1; usr_we = 0; usr_addr = 5'h03;
            n = 0; ns = 0;
            do begin @(negedge clk); n++; if (slv_gnt) ns++; end while (!usr_gnt && n < 40);
            chk("starve_slv_grants", ns, 4);
            chk("starve_usr_gnt", usr_gnt, 1);
            @(posedge clk); #1;
            slv_req = 0; usr_req = 0;
            @(negedge clk);
            chk("starve_rvalid", {usr_rvalid, slv_rvalid}, 2'b10);
            chk("starve_rdata", usr_rdata, model[3]);
        end
        access(0, 1, 5'h1F, 8'h5A);
        @(posedge clk); #1;
        mst_req = 1; mst_addr = 5'h1F; mst_wdata = 8'hFF;
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk("rstmid_no_gnt", mst_gnt, 0);
        @(posedge clk); #1;
        mst_req = 0; rst_n = 1;
        @(negedge clk);
        chk("rstmid_idle", {busy, mst_gnt, usr_rvalid, slv_rvalid}, 4'b0000);
        chk("rstmid_rdata_clr", usr_rdata, 8'h00);
        access(0, 0, 5'h1F, 8'h00);
        @(posedge clk); #1;
        mst_req = 1;
        for (int k = 0; k < 32; k++) begin
            mst_addr = k[4:0];
            mst_wdata = 8'($urandom);
            n = 0;
            do begin @(negedge clk); n++; end while (!mst_gnt && n < 10);
            chk("burst_spacing", n, 2);
            model[k] = mst_wdata;
            @(posedge clk); #1;
        end
        mst_req = 0;
        for (int k = 0; k < 32; k++) access(k % 2 == 1 ? 2 : 0, 1'b0, k[4:0], 8'h00);
        repeat (40) begin
            w = $urandom_range(0, 2);
            access(w, w == 1 ? 1'b1 : w == 0 ? 1'($urandom_range(0, 1)) : 1'b0,
                   5'($urandom), 8'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
